bit_serial_adder: RTL
=====================

// Module: bit_serial_adder
// PURPOSE
//   Adds two WIDTH-bit operands one bit per cycle, LSB first, with a registered carry.
//   The per-bit sum/carry function is the one_bit_adder full-add equation, extended with a carry-in.
//   The block sits upstream of the single-bit adder and sequences operands through it.
//   Valid/ready handshakes on both sides; one operation in flight at a time.
// PARAMETERS
//   WIDTH   8   operand and result width in bits; legal range WIDTH >= 1
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      operand pair and carry-in are valid
//   in_ready   out  1      block can accept an operand pair
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in into bit 0
//   out_valid  out  1      out_sum/out_cout hold a completed result
//   out_ready  in   1      consumer accepts the result
//   out_sum    out  WIDTH  sum bits [WIDTH-1:0]
//   out_cout   out  1      carry out of bit WIDTH-1
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Clock and reset: one clock (clk); reset is synchronous and active-high.
//   Reset (sampled high on any edge, including mid-operation):
//     - State goes to IDLE; the current operation is abandoned.
//     - out_valid=0, out_sum=0, out_cout=0, busy=0, carry reg=0, bit counter=0.
//     - in_ready=1 from the first cycle after reset deasserts.
//   FSM has 3 states: IDLE, RUN, DONE.
//   IDLE:
//     - in_ready=1.
//     - On in_valid&&in_ready: latch in_a/in_b into shift regs, carry<=in_cin, cnt<=0, go to RUN.
//   RUN (in_ready=0, in_valid ignored), each cycle:
//     - s = a[0]^b[0]^c; c <= (a[0]&b[0]) | (c&(a[0]^b[0])).
//     - a,b shift right; s shifts into out_sum MSB (out_sum >> 1 | s<<WIDTH-1); cnt++.
//     - On the cycle with cnt==WIDTH-1: go to DONE and set out_cout to the new carry.
//   DONE:
//     - out_valid=1; out_sum/out_cout held stable until handshake; in_ready=0.
//     - On out_valid&&out_ready: out_valid<=0, go to IDLE.
//     - out_sum/out_cout keep their last value until the next RUN.
//   Latency: acceptance at edge k gives out_valid=1 after edge k+WIDTH.
//     - Throughput is one result per WIDTH+2 cycles when out_ready is held high.
//   WIDTH=1: RUN lasts exactly one cycle.
//   Counter width is $clog2(WIDTH)+1; it never wraps within an operation.
//   out_sum during RUN is partial; it is only meaningful when out_valid=1.
//   Result equals {out_cout,out_sum} = in_a + in_b + in_cin, with no truncation before the carry.
//   Simultaneous in_valid while in DONE with out_ready: the result is consumed; the input is not
//     accepted until the following cycle (IDLE).
//   Reset has priority over every handshake.
// TESTING
//   WIDTH=8, a=0xFF, b=0x01, cin=0 -> out_valid 8 cycles after accept; sum=0x00, cout=1.
//   WIDTH=8, a=0x5A, b=0x33, cin=1 -> sum=0x8E, cout=0.
//   Hold out_ready=0 for 5 cycles in DONE -> out_sum/out_cout/out_valid stable; in_ready=0;
//     new in_valid pulses ignored.
//   Assert reset on the 3rd RUN cycle -> next cycle: out_valid=0, out_sum=0, busy=0;
//     in_ready=1 after release.
//   in_valid and out_ready held high, 4 back-to-back ops -> each accepted 1 cycle after the
//     previous result handshake; all 4 results correct.
//   WIDTH=4 exhaustive a,b,cin (512 cases), plus WIDTH=1 all 8 cases -> {cout,sum}==a+b+cin.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per cycle, LSB first,
// with a registered carry and valid/ready handshakes on both sides.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_shift;
  logic            carry;
  logic            s;
  logic            c_next;
  logic [CW-1:0]   cnt;

  assign s      = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_one
      assign sum_shift = s;
    end else begin : g_multi
      assign sum_shift = {s, out_sum[WIDTH-1:1]};
    end
  endgenerate

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry   <= c_next;
          out_sum <= sum_shift;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_cout  <= c_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
